// File: rtl/laser_pkg.sv
// Purpose : shared types and constants for the laser frame scheduler.
// Latency : n/a (types only).
// Backpr. : n/a.
// Contents: COORD_W, NUM_PTS, TAG_W, IDX_W, dispatch state enum, result struct, point word.
package laser_pkg;

    localparam int COORD_W = 4;
    localparam int NUM_PTS = 40;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_STORE = 2'd3
    } disp_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] c1x;
        logic [COORD_W-1:0] c1y;
        logic [COORD_W-1:0] c2x;
        logic [COORD_W-1:0] c2y;
        logic [TAG_W-1:0]   tag;
        logic               err;
    } res_t;

    // One stored point: {y, x}
    typedef logic [2*COORD_W-1:0] pt_t;

endpackage

// File: rtl/laser_res_fifo.sv
// Purpose : synchronous FIFO of engine results (res_t), DEPTH entries.
// Latency : a pushed entry is visible at dout_o the cycle after the push.
// Backpr. : push while full is dropped (caller gates on full_o); pop while empty is ignored.
// Ports   : CLK/RST_N, push_i/din_i, pop_i/dout_o, full_o, empty_o.
module laser_res_fifo
    import laser_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic push_i,
    input  res_t din_i,
    input  logic pop_i,
    output res_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    res_t        mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i && !full_o) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/laser_frame_sched.sv
// Purpose : double-buffered point store + dispatch FSM + tagged result FIFO for the laser engine.
// Latency : eng_start pulses the cycle after the completing beat; results appear 2 cycles after eng_done.
// Backpr. : in_ready low while the write bank is full; engine launch held while the result FIFO is full.
// Ports   : point stream (in_*), engine control/read port (eng_*), result stream (res_*), busy.
// Option  : LASER_SCHED_TIMEOUT_EN adds a RUN watchdog of TIMEOUT_CYC cycles that stores an err result.
module laser_frame_sched
    import laser_pkg::*;
#(
    parameter int RES_DEPTH   = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               eng_start,
    input  logic               eng_done,
    input  logic [COORD_W-1:0] eng_c1x,
    input  logic [COORD_W-1:0] eng_c1y,
    input  logic [COORD_W-1:0] eng_c2x,
    input  logic [COORD_W-1:0] eng_c2y,
    input  logic [IDX_W-1:0]   eng_rd_idx,
    output logic [COORD_W-1:0] eng_rd_x,
    output logic [COORD_W-1:0] eng_rd_y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COORD_W-1:0] res_c1x,
    output logic [COORD_W-1:0] res_c1y,
    output logic [COORD_W-1:0] res_c2x,
    output logic [COORD_W-1:0] res_c2y,
    output logic [TAG_W-1:0]   res_tag,
    output logic               res_err,
    output logic               busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTS - 1);
    localparam logic [IDX_W-1:0] PTS_IDX  = IDX_W'(NUM_PTS);

    // ---------------- point store ----------------
    pt_t              mem_q [2][NUM_PTS];
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q;
    logic             rd_bank_q;
    logic [IDX_W-1:0] cnt_q;
    logic [TAG_W-1:0] load_tag_q;
    logic [TAG_W-1:0] bank_tag_q [2];

    logic accept;
    logic last_beat;
    logic release_bank;

    assign in_ready  = !full_q[wr_bank_q];
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (cnt_q == LAST_IDX);

    // Set and clear never hit the same bank: a completing beat needs its bank
    // empty, while a release needs its bank full.
    always_comb begin
        full_d = full_q;
        if (last_beat) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            cnt_q      <= '0;
            load_tag_q <= '0;
            for (int b = 0; b < 2; b++) begin
                bank_tag_q[b] <= '0;
                for (int i = 0; i < NUM_PTS; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else begin
            full_q <= full_d;
            if (accept) begin
                mem_q[wr_bank_q][cnt_q] <= {in_y, in_x};
                if (cnt_q == LAST_IDX) begin
                    cnt_q                 <= '0;
                    wr_bank_q             <= ~wr_bank_q;
                    load_tag_q            <= load_tag_q + 8'd1;
                    bank_tag_q[wr_bank_q] <= load_tag_q;
                end else begin
                    cnt_q <= cnt_q + 6'd1;
                end
            end
            if (release_bank) begin
                rd_bank_q <= ~rd_bank_q;
            end
        end
    end

    // Engine read port always looks at the dispatch bank.
    pt_t rd_pt;
    always_comb begin
        rd_pt = '0;
        if (eng_rd_idx < PTS_IDX) begin
            rd_pt = mem_q[rd_bank_q][eng_rd_idx];
        end
    end
    assign eng_rd_x = rd_pt[COORD_W-1:0];
    assign eng_rd_y = rd_pt[2*COORD_W-1:COORD_W];

    // ---------------- dispatch FSM ----------------
    disp_state_e state_q, state_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        timeout_hit;
    logic        start_ok;

    // The completing beat counts as "full" in the same cycle so the engine
    // launches one cycle after that beat instead of two.
    assign start_ok = (full_q[rd_bank_q] || (last_beat && (wr_bank_q == rd_bank_q)))
                      && !fifo_full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (eng_done || timeout_hit) state_d = ST_STORE;
            ST_STORE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        eng_start    = (state_q == ST_START);
        fifo_push    = (state_q == ST_STORE);
        release_bank = (state_q == ST_STORE);
    end

`ifdef LASER_SCHED_TIMEOUT_EN
    localparam int                    RUN_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [RUN_CNT_W-1:0] RUN_LAST  = RUN_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RUN_CNT_W-1:0] RUN_ONE   = RUN_CNT_W'(1);

    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (state_q == ST_START) begin
            run_cnt_d = '0;
        end else if (state_q == ST_RUN && !eng_done) begin
            run_cnt_d = run_cnt_q + RUN_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    // Fires on the TIMEOUT_CYC-th RUN cycle that has no eng_done.
    assign timeout_hit = (state_q == ST_RUN) && !eng_done && (run_cnt_q == RUN_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Result latch; an abort stores zero centres with err set.
    logic [COORD_W-1:0] c1x_q, c1y_q, c2x_q, c2y_q;
    logic               err_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            c1x_q <= '0;
            c1y_q <= '0;
            c2x_q <= '0;
            c2y_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == ST_RUN) begin
            if (eng_done) begin
                c1x_q <= eng_c1x;
                c1y_q <= eng_c1y;
                c2x_q <= eng_c2x;
                c2y_q <= eng_c2y;
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                c1x_q <= '0;
                c1y_q <= '0;
                c2x_q <= '0;
                c2y_q <= '0;
                err_q <= 1'b1;
            end
        end
    end

    // ---------------- result FIFO ----------------
    res_t push_dat;
    res_t head_dat;

    always_comb begin
        push_dat     = '0;
        push_dat.c1x = c1x_q;
        push_dat.c1y = c1y_q;
        push_dat.c2x = c2x_q;
        push_dat.c2y = c2y_q;
        push_dat.tag = bank_tag_q[rd_bank_q];
        push_dat.err = err_q;
    end

    laser_res_fifo #(
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push_i  (fifo_push),
        .din_i   (push_dat),
        .pop_i   (res_ready && !fifo_empty),
        .dout_o  (head_dat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head fields read as zero while nothing is queued.
    res_t head_vis;
    assign head_vis  = fifo_empty ? '0 : head_dat;
    assign res_valid = !fifo_empty;
    assign res_c1x   = head_vis.c1x;
    assign res_c1y   = head_vis.c1y;
    assign res_c2x   = head_vis.c2x;
    assign res_c2y   = head_vis.c2y;
    assign res_tag   = head_vis.tag;
    assign res_err   = head_vis.err;

    assign busy = (|full_q) || (state_q != ST_IDLE) || res_valid;

endmodule

// File: tb/tb_laser_frame_sched.sv
module tb_laser_frame_sched;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       in_valid, in_ready;
    logic [3:0] in_x, in_y;
    logic       eng_start, eng_done;
    logic [3:0] eng_c1x, eng_c1y, eng_c2x, eng_c2y;
    logic [5:0] eng_rd_idx;
    logic [3:0] eng_rd_x, eng_rd_y;
    logic       res_valid, res_ready;
    logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
    logic [7:0] res_tag;
    logic       res_err, busy;

    int checks   = 0;
    int failures = 0;
    int eng_lat  = 20;
    int n_start  = 0;
    int start_base = 0;

    always #5 CLK = ~CLK;

    laser_frame_sched #(
        .RES_DEPTH   (2),
        .TIMEOUT_CYC (64)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_c1x    (eng_c1x),
        .eng_c1y    (eng_c1y),
        .eng_c2x    (eng_c2x),
        .eng_c2y    (eng_c2y),
        .eng_rd_idx (eng_rd_idx),
        .eng_rd_x   (eng_rd_x),
        .eng_rd_y   (eng_rd_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_c1x    (res_c1x),
        .res_c1y    (res_c1y),
        .res_c2x    (res_c2x),
        .res_c2y    (res_c2y),
        .res_tag    (res_tag),
        .res_err    (res_err),
        .busy       (busy)
    );

    // Engine model: answers eng_lat cycles after eng_start with C1=(8,8),
    // C2=(k,0) where k is the launch index since the last reset. eng_lat=0 never answers.
    initial begin : engine_model
        eng_done = 1'b0;
        eng_c1x = 4'd0; eng_c1y = 4'd0; eng_c2x = 4'd0; eng_c2y = 4'd0;
        forever begin
            @(posedge CLK); #2;
            if (eng_start === 1'b1) begin
                n_start++;
                if (eng_lat > 0) begin
                    repeat (eng_lat) @(posedge CLK);
                    #1;
                    eng_c1x  = 4'd8;
                    eng_c1y  = 4'd8;
                    eng_c2x  = 4'(n_start - start_base - 1);
                    eng_c2y  = 4'd0;
                    eng_done = 1'b1;
                    @(posedge CLK); #1;
                    eng_done = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; res_ready = 1'b0; eng_rd_idx = 6'd0; in_x = 4'd0; in_y = 4'd0;
        RST_N = 1'b0;
        tick(); tick();
        start_base = n_start;
        RST_N = 1'b1;
    endtask

    task automatic send_beat(input logic [3:0] x, input logic [3:0] y, input int budget);
        int n = 0;
        in_valid = 1'b1; in_x = x; in_y = y;
        while (in_ready !== 1'b1 && n < budget) begin
            tick(); n++;
        end
        if (in_ready !== 1'b1) check("beat_wait_expired", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // mode 0: every point (8,8); mode 1: point i = (i mod 16, i/16)
    task automatic send_frame(input int mode, input int budget);
        for (int i = 0; i < 40; i++) begin
            if (mode == 1) send_beat(4'(i % 16), 4'(i / 16), budget);
            else           send_beat(4'd8, 4'd8, budget);
        end
    endtask

    task automatic wait_res(input int budget);
        int n = 0;
        while (res_valid !== 1'b1 && n < budget) begin
            tick(); n++;
        end
        check("wait_res_valid", res_valid, 1);
    endtask

    task automatic pop_check(input int tag, input int c2x, input int err);
        wait_res(2000);
        check("res_tag", res_tag, tag);
        check("res_err", res_err, err);
        check("res_c1x", res_c1x, (err != 0) ? 0 : 8);
        check("res_c2x", res_c2x, (err != 0) ? 0 : c2x);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic sweep(input int n);
        logic [7:0] exp_pt;
        for (int i = 0; i < n; i++) begin
            eng_rd_idx = 6'(i);
            #2;
            exp_pt = {4'(i / 16), 4'(i % 16)};
            check("rd_point", {eng_rd_y, eng_rd_x}, exp_pt);
        end
        eng_rd_idx = 6'd0;
    endtask

    initial begin : stimulus
        int n;
        in_valid = 1'b0; res_ready = 1'b0; eng_rd_idx = 6'd0; in_x = 4'd0; in_y = 4'd0;

        // Reset values
        RST_N = 1'b0;
        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_eng_start", eng_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_c1x", res_c1x, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_res_err", res_err, 0);
        check("rst_busy", busy, 0);
        RST_N = 1'b1;
        tick();

        // Single frame, start latency and single pulse
        eng_lat = 20;
        send_frame(0, 10);
        check("start_after_last_beat", eng_start, 1);
        tick();
        check("start_one_cycle", eng_start, 0);
        check("busy_running", busy, 1);
        wait_res(100);
        check("res_c1y", res_c1y, 8);
        check("res_c2y", res_c2y, 0);
        pop_check(0, 0, 0);
        check("empty_after_pop", res_valid, 0);
        check("idle_not_busy", busy, 0);

        // Stray eng_done outside RUN
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick(); tick(); tick();
        check("stray_done_ignored", res_valid, 0);
        check("stray_done_no_start", eng_start, 0);

        // Read port during RUN, second frame in bank 1
        eng_lat = 60;
        send_frame(1, 10);
        tick(); tick();
        sweep(40);
        eng_rd_idx = 6'd45;
        #2;
        check("rd_out_of_range", {eng_rd_y, eng_rd_x}, 0);
        eng_rd_idx = 6'd0;
        pop_check(1, 1, 0);

        // Reset mid-load after 17 beats
        do_reset();
        for (int i = 0; i < 17; i++) send_beat(4'd15, 4'd15, 10);
        RST_N = 1'b0;
        tick();
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        RST_N = 1'b1;
        eng_lat = 40;
        tick();
        send_frame(1, 10);
        check("midrst_start", eng_start, 1);
        tick(); tick();
        sweep(17);
        pop_check(0, 0, 0);

        // Back-to-back frames with a slow engine
        do_reset();
        eng_lat = 500;
        send_frame(0, 10);
        send_frame(0, 10);
        check("both_banks_full", in_ready, 0);
        check("b2b_busy", busy, 1);
        in_valid = 1'b1; in_x = 4'd8; in_y = 4'd8;
        n = 0;
        while (in_ready !== 1'b1 && n < 1000) begin
            tick(); n++;
        end
        check("ready_after_store", in_ready, 1);
        check("store_same_cycle", res_valid, 1);
        check("first_store_tag", res_tag, 0);
        send_frame(0, 10);
        pop_check(0, 0, 0);
        pop_check(1, 1, 0);
        pop_check(2, 2, 0);

        // Result backpressure: FIFO of 2 holds the third launch
        do_reset();
        eng_lat = 20;
        for (int f = 0; f < 4; f++) send_frame(0, 500);
        repeat (30) tick();
        check("no_start_fifo_full", n_start - start_base, 2);
        check("bp_both_full", in_ready, 0);
        check("bp_head_tag", res_tag, 0);
        pop_check(0, 0, 0);
        n = 0;
        while ((n_start - start_base) < 3 && n < 50) begin
            tick(); n++;
        end
        check("start_after_pop", n_start - start_base, 3);
        pop_check(1, 1, 0);
        pop_check(2, 2, 0);
        pop_check(3, 3, 0);
        check("bp_drained_busy", busy, 0);

`ifdef LASER_SCHED_TIMEOUT_EN
        // Watchdog abort with a silent engine
        do_reset();
        eng_lat = 0;
        send_frame(0, 10);
        check("tmo_start", eng_start, 1);
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            tick(); n++;
        end
        check("tmo_cycles", n, 66);
        repeat (4) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        pop_check(0, 0, 1);
        tick();
        check("late_done_ignored", res_valid, 0);
        eng_lat = 20;
        send_frame(0, 10);
        pop_check(1, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
